// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad producer and core unit:
// key codes, entry-state encodings and operand sizing.
package calc_pkg;

  localparam int VAL_W          = 16;
  localparam int MAX_DIGITS_DEF = 3;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_AND = 4'hC;
  localparam logic [3:0] KEY_OR  = 4'hD;
  localparam logic [3:0] KEY_CMP = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRC  = 2'd1,
    ST_OP   = 2'd2,
    ST_DST  = 2'd3
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_oper(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_CMP);
  endfunction

endpackage

// File: rtl/dec_accumulate.sv
// Appends one decimal digit to a binary operand. Leading zeros are not
// counted as digits, and a full operand ignores further digits.
module dec_accumulate
  import calc_pkg::*;
#(
  parameter int MAX_D = MAX_DIGITS_DEF
) (
  input  logic [VAL_W-1:0] i_value,
  input  logic [3:0]       i_digit,
  input  logic [1:0]       i_count,
  output logic [VAL_W-1:0] o_value,
  output logic [1:0]       o_count,
  output logic             o_accept
);

  localparam logic [1:0] LP_MAX = 2'(MAX_D);

  logic [VAL_W-1:0] w_digit_ext;
  assign w_digit_ext = {{(VAL_W-4){1'b0}}, i_digit};

  // value*10 + d built from shifts; a zero value restarts with the new digit
  always_comb begin
    o_value  = i_value;
    o_count  = i_count;
    o_accept = (i_count != LP_MAX);
    if (o_accept) begin
      if (i_value == '0) begin
        o_value = w_digit_ext;
        o_count = 2'd1;
      end else begin
        o_value = (i_value << 3) + (i_value << 1) + w_digit_ext;
        o_count = i_count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/key_entry_unit.sv
// Keypad entry producer: turns key-press events into two operands, an
// operator code, an entry state, a digit count and a finish flag.
//
//  state   | meaning
//  --------+---------------------------------------------
//  ST_IDLE | nothing entered since reset
//  ST_SRC  | collecting digits of the first operand
//  ST_OP   | operator latched, waiting for second operand
//  ST_DST  | collecting digits of the second operand
module key_entry_unit
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic       IN_key_valid,
  input  logic [3:0] IN_key,
  output logic [7:0] OUT_SRCH,
  output logic [7:0] OUT_SRCL,
  output logic [7:0] OUT_DSTH,
  output logic [7:0] OUT_DSTL,
  output logic [3:0] OUT_ALU_OP,
  output logic       OUT_finish,
  output logic [1:0] OUT_state,
  output logic [1:0] OUT_flag
);

  entry_state_t     r_state;
  logic [VAL_W-1:0] r_src;
  logic [VAL_W-1:0] r_dst;
  logic [3:0]       r_op;
  logic             r_finish;
  logic [1:0]       r_flag;
  logic             r_prev;

  logic             w_evt;
  logic [VAL_W-1:0] w_acc_in;
  logic [VAL_W-1:0] w_acc_value;
  logic [1:0]       w_acc_count;
  logic             w_acc_accept;

  assign w_evt    = IN_key_valid & ~r_prev;
  assign w_acc_in = (r_state == ST_DST) ? r_dst : r_src;

  dec_accumulate #(
    .MAX_D(MAX_DIGITS)
  ) u_acc (
    .i_value (w_acc_in),
    .i_digit (IN_key),
    .i_count (r_flag),
    .o_value (w_acc_value),
    .o_count (w_acc_count),
    .o_accept(w_acc_accept)
  );

  // Entry FSM with edge-detected key events. The history register follows
  // the key level even during reset, so a key held through reset must be
  // released and pressed again before it counts.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_op     <= '0;
      r_finish <= 1'b0;
      r_flag   <= '0;
      r_prev   <= IN_key_valid;
    end else begin
      r_prev <= IN_key_valid;
      if (w_evt) begin
        if (is_digit(IN_key)) begin
          if (r_state == ST_IDLE || r_finish) begin
            r_src    <= {{(VAL_W-4){1'b0}}, IN_key};
            r_dst    <= '0;
            r_op     <= '0;
            r_finish <= 1'b0;
            r_flag   <= 2'd1;
            r_state  <= ST_SRC;
          end else begin
            case (r_state)
              ST_SRC: begin
                if (w_acc_accept) begin
                  r_src  <= w_acc_value;
                  r_flag <= w_acc_count;
                end
              end
              ST_OP: begin
                r_dst   <= {{(VAL_W-4){1'b0}}, IN_key};
                r_flag  <= 2'd1;
                r_state <= ST_DST;
              end
              ST_DST: begin
                if (w_acc_accept) begin
                  r_dst  <= w_acc_value;
                  r_flag <= w_acc_count;
                end
              end
              default: ;
            endcase
          end
        end else if (is_oper(IN_key)) begin
          if (!r_finish && (r_state == ST_SRC || r_state == ST_OP)) begin
            r_op    <= IN_key;
            r_state <= ST_OP;
          end
        end else if (IN_key == KEY_EQ) begin
          if (!r_finish && r_state == ST_DST) begin
            r_finish <= 1'b1;
          end
        end
      end
    end
  end

  assign OUT_SRCH   = r_src[15:8];
  assign OUT_SRCL   = r_src[7:0];
  assign OUT_DSTH   = r_dst[15:8];
  assign OUT_DSTL   = r_dst[7:0];
  assign OUT_ALU_OP = r_op;
  assign OUT_finish = r_finish;
  assign OUT_state  = r_state;
  assign OUT_flag   = r_flag;

endmodule

// File: tb/tb_key_entry_unit.sv
// Bench for key_entry_unit: per-cycle scoreboard fed by a behavioural
// calculator-entry model, plus directed end-of-sequence checks.
module tb_key_entry_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kv  = 1'b0;
  logic [3:0] key = 4'h0;
  logic [7:0] srch, srcl, dsth, dstl;
  logic [3:0] alu_op;
  logic       finish;
  logic [1:0] state, flag;

  always #5 clk = ~clk;

  key_entry_unit dut (
    .IN_clk      (clk),
    .IN_rst      (rst),
    .IN_key_valid(kv),
    .IN_key      (key),
    .OUT_SRCH    (srch),
    .OUT_SRCL    (srcl),
    .OUT_DSTH    (dsth),
    .OUT_DSTL    (dstl),
    .OUT_ALU_OP  (alu_op),
    .OUT_finish  (finish),
    .OUT_state   (state),
    .OUT_flag    (flag)
  );

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [3:0]  op;
    logic        fin;
    logic [1:0]  st;
    logic [1:0]  fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // behavioural model state
  int m_src = 0, m_dst = 0, m_op = 0, m_st = 0, m_fl = 0;
  bit m_fin = 0, m_prev = 0;

  function automatic exp_t got_now();
    exp_t g;
    g.src = {srch, srcl};
    g.dst = {dsth, dstl};
    g.op  = alu_op;
    g.fin = finish;
    g.st  = state;
    g.fl  = flag;
    return g;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.src = m_src[15:0];
    e.dst = m_dst[15:0];
    e.op  = m_op[3:0];
    e.fin = m_fin;
    e.st  = m_st[1:0];
    e.fl  = m_fl[1:0];
    return e;
  endfunction

  task automatic compare(input string name, input exp_t g, input exp_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s t=%0t got src=%0d dst=%0d op=%h fin=%b st=%0d fl=%0d required src=%0d dst=%0d op=%h fin=%b st=%0d fl=%0d",
               name, $time, g.src, g.dst, g.op, g.fin, g.st, g.fl,
               e.src, e.dst, e.op, e.fin, e.st, e.fl);
    end
  endtask

  // decimal append: leading zero restarts, full operand ignores the digit
  task automatic add_digit(inout int v, inout int n, input int d);
    if (n >= 3) return;
    if (v == 0) begin
      v = d;
      n = 1;
    end else begin
      v = v * 10 + d;
      n = n + 1;
    end
  endtask

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_st == 0 || m_fin) begin
        m_src = k; m_dst = 0; m_op = 0; m_fin = 0; m_fl = 1; m_st = 1;
      end else if (m_st == 1) begin
        add_digit(m_src, m_fl, k);
      end else if (m_st == 2) begin
        m_dst = k; m_fl = 1; m_st = 3;
      end else begin
        add_digit(m_dst, m_fl, k);
      end
    end else if (k <= 14) begin
      if (!m_fin && (m_st == 1 || m_st == 2)) begin
        m_op = k; m_st = 2;
      end
    end else begin
      if (!m_fin && m_st == 3) m_fin = 1;
    end
  endtask

  // one clock of stimulus; the outcome of this cycle is queued for the monitor
  task automatic step(input bit r, input bit v, input int k);
    @(negedge clk);
    rst = r;
    kv  = v;
    key = k[3:0];
    if (r) begin
      m_src = 0; m_dst = 0; m_op = 0; m_fin = 0; m_st = 0; m_fl = 0;
    end else if (v && !m_prev) begin
      model_key(k);
    end
    m_prev = v;
    q.push_back(model_now());
  endtask

  task automatic press(input int k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) step(0, 1, k);
    for (int i = 0; i < gap; i++) step(0, 0, k);
  endtask

  task automatic seq(input int keys[$]);
    foreach (keys[i]) press(keys[i], 1, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  // directed check against spelled-out expected values
  task automatic chk(input string name, input int s, input int d, input int op,
                     input bit fin, input int st, input int fl);
    exp_t e;
    e.src = s[15:0]; e.dst = d[15:0]; e.op = op[3:0];
    e.fin = fin; e.st = st[1:0]; e.fl = fl[1:0];
    @(posedge clk);
    #2;
    compare(name, got_now(), e);
  endtask

  // monitor: after every active edge, compare outputs with queued expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        compare("scoreboard", got_now(), e);
      end
    end
  end

  initial begin
    int r, k;
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("reset_state", 0, 0, 0, 0, 0, 0);

    seq('{1, 2, 3, 10, 4, 5, 15});
    chk("basic_expr", 123, 45, 10, 1, 3, 2);
    seq('{9});
    chk("restart_after_eq", 9, 0, 0, 0, 1, 1);
    seq('{10, 2, 15, 11});
    chk("op_after_eq_ignored", 9, 2, 10, 1, 3, 1);

    do_reset();
    seq('{1, 2, 3, 4});
    chk("max_digits", 123, 0, 0, 0, 1, 3);

    do_reset();
    seq('{0, 0, 5});
    chk("leading_zeros", 5, 0, 0, 0, 1, 1);
    seq('{11, 12, 7, 15});
    chk("op_replace", 5, 7, 12, 1, 3, 1);

    do_reset();
    press(7, 10, 2);
    chk("held_key_once", 7, 0, 0, 0, 1, 1);
    seq('{15});
    chk("eq_in_src_ignored", 7, 0, 0, 0, 1, 1);

    do_reset();
    seq('{1, 10, 2});
    step(1, 1, 3);
    step(1, 1, 3);
    step(0, 1, 3);
    step(0, 1, 3);
    step(0, 0, 3);
    chk("held_through_reset", 0, 0, 0, 0, 0, 0);
    seq('{4});
    chk("repress_after_reset", 4, 0, 0, 0, 1, 1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 15));
        step(0, 0, 0);
      end else begin
        if (r < 63)      k = $urandom_range(0, 9);
        else if (r < 88) k = $urandom_range(10, 14);
        else             k = 15;
        press(k, $urandom_range(1, 3), $urandom_range(1, 2));
      end
    end

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
